// File: rtl/fifo_vc.sv
// fifo_vc: synchronous circular-buffer FIFO with a registered read port,
// level counter, threshold flags and a sticky overflow/underflow flag.
// It is used as the per-class virtual-channel buffer ahead of the class-demux arbiter.
//
// Ports:
//   clk          rising-edge clock
//   reset_L      asynchronous active-low reset
//   push         write request; data_in is stored when accepted
//   pop          read request
//   data_in      write data (the two MSBs carry the packet class)
//   data_out     registered read data; holds its value between accepted pops
//   fifo_empty   level == 0
//   fifo_full    level == depth
//   almost_full  level >= AF_THRESH
//   almost_empty level <= AE_THRESH
//   fifo_count   current level, 0..depth
//   error        sticky; set by overflow or underflow, cleared only by reset
module fifo_vc #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 2,
   parameter int AF_THRESH  = 3,
   parameter int AE_THRESH  = 1
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  error
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

   // Reject threshold settings outside their legal ranges at elaboration.
   generate
      if (AF_THRESH <= 0 || AF_THRESH > DEPTH) begin : g_bad_af
         $error("fifo_vc: AF_THRESH out of range");
      end
      if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
         $error("fifo_vc: AE_THRESH out of range");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic [DATA_WIDTH-1:0] dout_q,   dout_d;
   logic                  error_q,  error_d;
   logic                  pop_acc, push_acc;

   // The flags come straight off the registered level.
   assign fifo_empty   = (count_q == '0);
   assign fifo_full    = (count_q == DEPTH_C);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign fifo_count   = count_q;
   assign data_out     = dout_q;
   assign error        = error_q;

   // A pop on an empty FIFO is never accepted, even with a push in the same
   // cycle, so there is no write-through path. A push on a full FIFO is
   // accepted only when a pop frees the slot in the same cycle.
   assign pop_acc  = pop & ~fifo_empty;
   assign push_acc = push & (~fifo_full | pop_acc);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
         dout_d   = mem_q[rd_ptr_q];
      end
      case ({push_acc, pop_acc})
         2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
      // Any rejected request is an overflow or an underflow.
      error_d = error_q | (push & ~push_acc) | (pop & ~pop_acc);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         error_q  <= error_d;
      end
   end

   // Storage is not reset; stale contents are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wr_ptr_q] <= data_in;
   end

endmodule

// File: tb/tb_fifo_vc.sv
module tb_fifo_vc;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       push, pop;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       fifo_empty, fifo_full, almost_full, almost_empty, error;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;

   // Reference model: stored words, expected read data, level, error.
   logic [7:0] mem_model [$];
   logic [7:0] exp_q [$];
   int         mcount;
   logic       merr;
   logic [7:0] mdout;

   fifo_vc #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1)) dut (
      .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
      .data_out(data_out), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .fifo_count(fifo_count), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mem_model.delete();
      exp_q.delete();
      mcount = 0;
      merr   = 1'b0;
      mdout  = 8'h00;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".count"}, 32'(fifo_count), 32'(mcount));
      chk({tag, ".empty"}, 32'(fifo_empty), 32'(mcount == 0));
      chk({tag, ".full"},  32'(fifo_full),  32'(mcount == 4));
      chk({tag, ".af"},    32'(almost_full),  32'(mcount >= 3));
      chk({tag, ".ae"},    32'(almost_empty), 32'(mcount <= 1));
      chk({tag, ".err"},   32'(error), 32'(merr));
      chk({tag, ".dout"},  32'(data_out), 32'(mdout));
   endtask

   // One clock of stimulus, model update and output checks.
   task automatic cycle(input string tag, input logic p, input logic o, input logic [7:0] d);
      bit pa, wa;
      @(negedge clk);
      push = p; pop = o; data_in = d;
      pa = o && (mcount != 0);
      wa = p && ((mcount != 4) || pa);
      if (pa) exp_q.push_back(mem_model.pop_front());
      if (wa) mem_model.push_back(d);
      if ((p && !wa) || (o && !pa)) merr = 1'b1;
      mcount = mcount + int'(wa) - int'(pa);
      @(posedge clk);
      #1;
      if (pa) mdout = exp_q.pop_front();
      chk_all(tag);
   endtask

   initial begin
      model_reset();
      reset_L = 1'b0; push = 1'b1; pop = 1'b0; data_in = 8'hAA;
      #1 chk_all("rst0");
      repeat (2) begin
         @(posedge clk); #1 chk_all("rst");
      end
      @(negedge clk);
      push = 1'b0;
      reset_L = 1'b1;

      // Fill to full.
      cycle("fill1", 1, 0, 8'h11);
      cycle("fill2", 1, 0, 8'h22);
      cycle("fill3", 1, 0, 8'h33);
      cycle("fill4", 1, 0, 8'h44);
      // Overflow, then drain.
      cycle("ovf", 1, 0, 8'h55);
      for (int i = 0; i < 4; i++) cycle("drain", 0, 1, 8'h00);

      // Wrap-around at level 2.
      cycle("pre1", 1, 0, 8'hA1);
      cycle("pre2", 1, 0, 8'hA2);
      for (int i = 0; i < 10; i++) cycle("wrap", 1, 1, 8'(i + 1));
      cycle("wdrn1", 0, 1, 8'h00);
      cycle("wdrn2", 0, 1, 8'h00);

      // Clean reset so the collision is what sets error.
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
      reset_L = 1'b0;
      model_reset();
      #1 chk_all("srst");
      @(negedge clk);
      reset_L = 1'b1;
      cycle("p5a", 1, 0, 8'h5A);
      cycle("r5a", 0, 1, 8'h00);
      cycle("coll", 1, 1, 8'h7E);
      cycle("r7e", 0, 1, 8'h00);

      // Async reset mid-fill at level 3.
      cycle("af1", 1, 0, 8'hC1);
      cycle("af2", 1, 0, 8'hC2);
      cycle("af3", 1, 0, 8'hC3);
      chk("lvl3", 32'(fifo_count), 32'd3);
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
      #2;
      reset_L = 1'b0;
      model_reset();
      #1 chk_all("arst");
      @(negedge clk);
      reset_L = 1'b1;
      cycle("p99", 1, 0, 8'h99);
      cycle("r99", 0, 1, 8'h00);
      chk("r99.val", 32'(data_out), 32'h99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
